// File: rtl/wdt_axi_regs.sv
// AXI4 slave register block for the watchdog core: drives WDEN/WDLIVE/WTOCNT, samples WTO,
// stretches kicks to LIVE_HOLD cycles and keeps a sticky timeout interrupt.
module wdt_axi_regs #(
  parameter int ID_W      = 8,
  parameter int LIVE_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] AWID,
  input  logic [31:0]     AWADDR,
  input  logic [3:0]      AWLEN,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [31:0]     WDATA,
  input  logic [3:0]      WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [ID_W-1:0] BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [ID_W-1:0] ARID,
  input  logic [31:0]     ARADDR,
  input  logic [3:0]      ARLEN,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [31:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            WDEN,
  output logic            WDLIVE,
  output logic [31:0]     WTOCNT,
  input  logic            WTO,
  output logic            wdt_irq
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [11:0] A_WDEN      = 12'h100;
  localparam logic [11:0] A_LIVE      = 12'h200;
  localparam logic [11:0] A_WTOCNT    = 12'h300;
  localparam logic [11:0] A_STATUS    = 12'h400;
  localparam int          HOLD_W      = $clog2(LIVE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LIVE_HOLD);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t          w_state_q, w_state_d;
  r_state_t          r_state_q, r_state_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d, rid_q, rid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [11:0]       waddr_q, waddr_d;
  logic [3:0]        wlen_q, wlen_d, rrem_q, rrem_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wden_q, wden_d, live_q, live_d, sticky_q, sticky_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       wtocnt_q, wtocnt_d, wtocnt_merged;
  logic              wr_en;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{AWADDR[31:12], ARADDR[31:12]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_wtocnt_lane
    assign wtocnt_merged[8*gi +: 8] = WSTRB[gi] ? WDATA[8*gi +: 8] : wtocnt_q[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rrem_q    <= '0;
      wden_q    <= 1'b0;
      live_q    <= 1'b0;
      hold_q    <= '0;
      wtocnt_q  <= '0;
      sticky_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rrem_q    <= rrem_d;
      wden_q    <= wden_d;
      live_q    <= live_d;
      hold_q    <= hold_d;
      wtocnt_q  <= wtocnt_d;
      sticky_q  <= sticky_d;
    end
  end

  // Write channel: READY/VALID are registered, so each is set on the transition into its state.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          bid_d     = AWID;
          waddr_d   = AWADDR[11:0];
          wlen_d    = AWLEN;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q && WLAST) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          if (wlen_q != 4'd0) begin
            bresp_d = RESP_SLVERR;
          end else if (waddr_q == A_WDEN || waddr_q == A_LIVE ||
                       waddr_q == A_WTOCNT || waddr_q == A_STATUS) begin
            bresp_d = RESP_OKAY;
            wr_en   = 1'b1;
          end else begin
            bresp_d = RESP_DECERR;
          end
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register file; the WTO set is applied last so it beats a same-cycle W1C.
  always_comb begin
    wden_d   = wden_q;
    live_d   = live_q;
    hold_d   = hold_q;
    wtocnt_d = wtocnt_q;
    sticky_d = sticky_q;
    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HOLD_W'(1)) live_d = 1'b0;
    end
    if (wr_en) begin
      case (waddr_q)
        A_WDEN: begin
          if (WSTRB[0]) begin
            wden_d = WDATA[0];
            if (!WDATA[0]) begin
              live_d = 1'b0;
              hold_d = '0;
            end
          end
        end
        A_LIVE: begin
          if (WSTRB[0]) begin
            live_d = WDATA[0];
            hold_d = WDATA[0] ? HOLD_LOAD : '0;
          end
        end
        A_WTOCNT: wtocnt_d = wtocnt_merged;
        A_STATUS: if (WSTRB[0] && WDATA[1]) sticky_d = 1'b0;
        default: ;
      endcase
    end
    if (WTO) sticky_d = 1'b1;
  end

  // Read channel: data is snapshotted at AR accept, so a same-cycle write is not visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rrem_d    = rrem_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = ARID;
          rrem_d    = ARLEN;
          rlast_d   = (ARLEN == 4'd0);
          r_state_d = R_DATA;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
          if (ARLEN != 4'd0) begin
            rresp_d = RESP_SLVERR;
          end else begin
            case (ARADDR[11:0])
              A_WDEN:   rdata_d = {31'b0, wden_q};
              A_LIVE:   rdata_d = {31'b0, live_q};
              A_WTOCNT: rdata_d = wtocnt_q;
              A_STATUS: rdata_d = {30'b0, sticky_q, WTO};
              default:  rresp_d = RESP_DECERR;
            endcase
          end
        end
      end
      R_DATA: begin
        if (RREADY && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rrem_d  = rrem_q - 1'b1;
            rlast_d = (rrem_q == 4'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign WDEN    = wden_q;
  assign WDLIVE  = live_q;
  assign WTOCNT  = wtocnt_q;
  assign wdt_irq = sticky_q;

endmodule

// File: tb/tb_wdt_axi_regs.sv
// Bench for wdt_axi_regs: directed steps plus randomized traffic checked against a
// register-level model (kick tracked as "high until cycle N").
module tb_wdt_axi_regs;
  localparam int ID_W      = 8;
  localparam int LIVE_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ID_W-1:0] AWID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA, WTOCNT;
  logic [3:0]  AWLEN = '0, WSTRB = '0, ARLEN = '0;
  logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic [1:0] BRESP, RRESP;
  logic BVALID, BREADY = 1'b1, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b1;
  logic WDEN, WDLIVE, WTO = 1'b0, wdt_irq;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_wden = 1'b0;
  int          m_live_until = 0;
  logic [31:0] m_wtocnt = '0;
  logic        m_sticky = 1'b0;
  logic        m_wto = 1'b0;

  int              last_c;
  logic [ID_W-1:0] last_awid, last_arid;
  logic [31:0]     rd_data[16];
  logic [1:0]      rd_resp[16];
  logic            rd_last[16];
  logic [ID_W-1:0] rd_id[16];
  int              rd_n, rd_k;

  wdt_axi_regs #(.ID_W(ID_W), .LIVE_HOLD(LIVE_HOLD)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT), .WTO(WTO), .wdt_irq(wdt_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [11:0] a, input logic [3:0] len);
    if (len != 4'd0) return 2'b10;
    if (a == 12'h100 || a == 12'h200 || a == 12'h300 || a == 12'h400) return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input int k);
    case (a)
      12'h100: return {31'b0, m_wden};
      12'h200: return (k < m_live_until) ? 32'd1 : 32'd0;
      12'h300: return m_wtocnt;
      12'h400: return {30'b0, m_sticky, m_wto};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb,
                             input logic [3:0] len, input int c);
    if (len == 4'd0) begin
      case (a)
        12'h100: if (strb[0]) begin
          m_wden = d[0];
          if (!d[0]) m_live_until = c;
        end
        12'h200: if (strb[0]) m_live_until = d[0] ? c + LIVE_HOLD : c;
        12'h300: for (int i = 0; i < 4; i++) if (strb[i]) m_wtocnt[8*i +: 8] = d[8*i +: 8];
        12'h400: if (strb[0] && d[1] && !m_wto) m_sticky = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_wden = 1'b0; m_live_until = 0; m_wtocnt = '0; m_sticky = 1'b0;
  endtask

  // Returns at the negedge one cycle after the WLAST beat was accepted.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] len, input int gap,
                           output logic [1:0] resp, output logic [ID_W-1:0] id_seen, output logic bv);
    int t;
    last_awid = ID_W'($urandom);
    AWID = last_awid; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    repeat (gap) @(negedge clk);
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = (b == int'(len)) ? data : $urandom;
      WSTRB = strb; WLAST = (b == int'(len)); WVALID = 1'b1;
      t = 0;
      while (WREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("w_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    last_c = cyc; resp = BRESP; id_seen = BID; bv = BVALID;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [3:0] len, input int gap);
    logic [1:0] resp; logic [ID_W-1:0] id_seen; logic bv;
    axi_write(addr, data, strb, len, gap, resp, id_seen, bv);
    model_write(addr[11:0], data, strb, len, last_c);
    chk("bvalid", {31'b0, bv}, 32'd1);
    chk("bresp", {30'b0, resp}, {30'b0, exp_resp(addr[11:0], len)});
    chk("bid", {24'b0, id_seen}, {24'b0, last_awid});
    $display("WR addr=%08h data=%08h strb=%b len=%0d bresp=%0d cyc=%0d", addr, data, strb, len, resp, last_c);
  endtask

  // hold>0 keeps RREADY low for that many RVALID cycles to check the R fields stay stable.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input int hold);
    int t, held; logic done; logic [31:0] hdata;
    held = 0; done = 1'b0; hdata = '0;
    RREADY = (hold == 0);
    last_arid = ID_W'($urandom);
    ARID = last_arid; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ar_timeout", 32'd0, 32'd1);
    rd_k = cyc;
    @(negedge clk);
    ARVALID = 1'b0;
    rd_n = 0;
    for (int t2 = 0; t2 < 60 && !done; t2++) begin
      if (RVALID === 1'b1) begin
        if (RREADY === 1'b0) begin
          if (held == 0) hdata = RDATA;
          else chk("r_stable", RDATA, hdata);
          held++;
          if (held >= hold) RREADY = 1'b1;
        end
        if (RREADY === 1'b1) begin
          rd_data[rd_n] = RDATA; rd_resp[rd_n] = RRESP; rd_last[rd_n] = RLAST; rd_id[rd_n] = RID;
          rd_n++;
          if (RLAST === 1'b1 || rd_n == 16) done = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (!done) chk("r_timeout", 32'd0, 32'd1);
    RREADY = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input int hold);
    logic [31:0] exp_d; logic [1:0] er;
    axi_read(addr, len, hold);
    exp_d = (len == 4'd0) ? model_read(addr[11:0], rd_k) : 32'd0;
    er = exp_resp(addr[11:0], len);
    chk("r_beats", rd_n, int'(len) + 1);
    for (int i = 0; i < rd_n; i++) begin
      chk("rdata", rd_data[i], exp_d);
      chk("rresp", {30'b0, rd_resp[i]}, {30'b0, er});
      chk("rlast", {31'b0, rd_last[i]}, {31'b0, i == int'(len)});
      chk("rid", {24'b0, rd_id[i]}, {24'b0, last_arid});
    end
    $display("RD addr=%08h len=%0d beats=%0d data=%08h rresp=%0d", addr, len, rd_n,
             (rd_n > 0) ? rd_data[0] : 32'd0, (rd_n > 0) ? rd_resp[0] : 2'd0);
  endtask

  initial begin
    int c1, c2, t;
    logic [11:0] tbl[5];
    logic [31:0] r, data;
    logic [3:0]  len;
    tbl = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {23'b0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, WDEN, WDLIVE, wdt_irq}, 32'd0);
    chk("rst_ids", {12'b0, BID, RID, BRESP, RRESP}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_wtocnt", WTOCNT, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic write/readback with R held for 3 cycles
    do_write(32'h300, 32'h0000_0040, 4'hF, 4'd0, 0);
    do_read(32'h300, 4'd0, 3);
    chk("wtocnt_readback", rd_data[0], 32'h0000_0040);

    // byte strobes
    do_write(32'h300, 32'hFFFF_FFFF, 4'hF, 4'd0, 0);
    do_write(32'h300, 32'h0000_00AB, 4'b0001, 4'd0, 0);
    chk("wtocnt_strobe", WTOCNT, 32'hFFFF_FFAB);
    do_read(32'h300, 4'd0, 0);

    // kick while WDEN=0: high exactly LIVE_HOLD cycles
    do_write(32'h200, 32'd1, 4'hF, 4'd0, 0);
    c1 = last_c; t = 0;
    while (WDLIVE === 1'b1 && t < 40) begin @(negedge clk); t++; end
    chk("kick_len", cyc - c1, LIVE_HOLD);

    // AW then W three cycles later, B held under BREADY=0
    chk("wden_before", {31'b0, WDEN}, 32'd0);
    BREADY = 1'b0;
    do_write(32'h100, 32'd1, 4'hF, 4'd0, 3);
    chk("wden_after", {31'b0, WDEN}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'b0, BVALID}, 32'd1);
    end
    BREADY = 1'b1;
    @(negedge clk);
    chk("bvalid_drop", {31'b0, BVALID}, 32'd0);

    // rekick during hold extends the pulse
    do_write(32'h200, 32'd1, 4'hF, 4'd0, 0);
    c1 = last_c;
    repeat (3) @(negedge clk);
    do_write(32'h200, 32'd1, 4'hF, 4'd0, 0);
    c2 = last_c; t = 0;
    while (WDLIVE === 1'b1 && t < 40) begin @(negedge clk); t++; end
    chk("rekick_len", cyc - c1, (c2 - c1) + LIVE_HOLD);

    // write 0 mid-hold drops at once
    do_write(32'h200, 32'd1, 4'hF, 4'd0, 0);
    do_write(32'h200, 32'd0, 4'hF, 4'd0, 0);
    chk("live_kill", {31'b0, WDLIVE}, 32'd0);

    // WDEN=0 cancels the hold
    do_write(32'h200, 32'd1, 4'hF, 4'd0, 0);
    do_write(32'h100, 32'd0, 4'hF, 4'd0, 0);
    chk("live_wden_off", {31'b0, WDLIVE}, 32'd0);
    repeat (10) @(negedge clk);
    chk("live_stays_off", {31'b0, WDLIVE}, 32'd0);

    // sticky timeout
    WTO = 1'b1; m_wto = 1'b1;
    @(negedge clk);
    WTO = 1'b0; m_wto = 1'b0; m_sticky = 1'b1;
    repeat (4) @(negedge clk);
    chk("irq_sticky", {31'b0, wdt_irq}, {31'b0, m_sticky});
    do_read(32'h400, 4'd0, 0);
    chk("status_sticky", rd_data[0], 32'h2);
    WTO = 1'b1; m_wto = 1'b1;
    @(negedge clk);
    do_read(32'h400, 4'd0, 0);
    do_write(32'h400, 32'h2, 4'hF, 4'd0, 0);
    chk("w1c_vs_wto", {31'b0, wdt_irq}, 32'd1);
    WTO = 1'b0; m_wto = 1'b0;
    @(negedge clk);
    do_write(32'h400, 32'h2, 4'hF, 4'd0, 0);
    chk("w1c_clear", {31'b0, wdt_irq}, 32'd0);
    do_read(32'h400, 4'd0, 0);

    // decode errors and bursts
    do_write(32'h500, 32'h1234_5678, 4'hF, 4'd0, 0);
    do_read(32'h500, 4'd0, 0);
    do_write(32'h300, 32'h1234_5678, 4'hF, 4'd3, 0);
    chk("burst_no_change", WTOCNT, m_wtocnt);
    do_read(32'h300, 4'd0, 0);
    do_read(32'h300, 4'd1, 0);

    // randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      data = $urandom;
      len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      do_write({r[31:12], tbl[$urandom_range(0, 4)]}, data, 4'($urandom), len, $urandom_range(0, 2));
      chk("rnd_wden", {31'b0, WDEN}, {31'b0, m_wden});
      chk("rnd_wdlive", {31'b0, WDLIVE}, (cyc < m_live_until) ? 32'd1 : 32'd0);
      chk("rnd_wtocnt", WTOCNT, m_wtocnt);
      chk("rnd_irq", {31'b0, wdt_irq}, {31'b0, m_sticky});
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom;
        len = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
        do_read({r[31:12], tbl[$urandom_range(0, 4)]}, len, $urandom_range(0, 2));
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // reset in the middle of a write
    do_write(32'h300, 32'hA5A5_0001, 4'hF, 4'd0, 0);
    do_write(32'h100, 32'd1, 4'hF, 4'd0, 0);
    AWID = 8'h5A; AWADDR = 32'h100; AWLEN = 4'd0; AWVALID = 1'b1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_ctrl", {23'b0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, WDEN, WDLIVE, wdt_irq}, 32'd0);
    chk("midrst_wtocnt", WTOCNT, 32'd0);
    WVALID = 1'b0; WLAST = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_b", {31'b0, BVALID}, 32'd0);
    chk("midrst_awready", {31'b0, AWREADY}, 32'd1);
    do_read(32'h300, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
